// File: rtl/acorn128_auth_release_if.sv
// Host/core-side bundle for the ACORN-128 authentication gate.
// The master drives session and core results; the slave (the gate) returns plaintext and status.
interface acorn128_auth_release_if #(
  parameter int TAG_BITS = 128
);
  logic                start_in;
  logic [TAG_BITS-1:0] rx_tag_in;
  logic                core_ready_in;
  logic [TAG_BITS-1:0] core_text_in;
  logic [TAG_BITS-1:0] core_tag_in;
  logic                out_ready_in;
  logic [TAG_BITS-1:0] plaintext_out;
  logic                pt_valid_out;
  logic                auth_ok_out;
  logic                auth_fail_out;
  logic                timeout_out;
  logic                busy_out;

  modport master (
    output start_in, rx_tag_in, core_ready_in, core_text_in, core_tag_in, out_ready_in,
    input  plaintext_out, pt_valid_out, auth_ok_out, auth_fail_out, timeout_out, busy_out
  );

  modport slave (
    input  start_in, rx_tag_in, core_ready_in, core_text_in, core_tag_in, out_ready_in,
    output plaintext_out, pt_valid_out, auth_ok_out, auth_fail_out, timeout_out, busy_out
  );
endinterface

// File: rtl/acorn128_auth_release.sv
// Receiver-side tag check for acorn128_top decryption: constant-time tag compare,
// plaintext released only on a full match and zeroised on any failure.
module acorn128_auth_release #(
  parameter int TAG_BITS       = 128,
  parameter int CMP_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                    clk,
  input logic                    rst,
  acorn128_auth_release_if.slave bus
);
  localparam int NWORDS = TAG_BITS / CMP_WIDTH;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMPARE,
    ST_RELEASE,
    ST_FAIL
  } state_t;

  state_t              state;
  logic [TAG_BITS-1:0] rx_tag;
  logic [TAG_BITS-1:0] core_tag;
  logic [TAG_BITS-1:0] text;
  logic [TAG_BITS-1:0] plaintext;
  logic [CMP_WIDTH-1:0] diff;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    cnt;
  logic                pt_valid;
  logic                auth_ok;
  logic                auth_fail;
  logic                timeout_flag;
  logic                busy;

  // Both tags shift down one word per compare cycle, so the low word is always the one compared.
  logic [CMP_WIDTH-1:0] diff_next;
  assign diff_next = diff | (rx_tag[CMP_WIDTH-1:0] ^ core_tag[CMP_WIDTH-1:0]);

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all state updates see the pre-edge values together.
    if (rst) begin
      state        <= ST_IDLE;
      rx_tag       <= '0;
      core_tag     <= '0;
      text         <= '0;
      plaintext    <= '0;
      diff         <= '0;
      idx          <= '0;
      cnt          <= '0;
      pt_valid     <= 1'b0;
      auth_ok      <= 1'b0;
      auth_fail    <= 1'b0;
      timeout_flag <= 1'b0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start_in) begin
            rx_tag       <= bus.rx_tag_in;
            auth_ok      <= 1'b0;
            auth_fail    <= 1'b0;
            timeout_flag <= 1'b0;
            cnt          <= '0;
            busy         <= 1'b1;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.core_ready_in) begin
            text     <= bus.core_text_in;
            core_tag <= bus.core_tag_in;
            diff     <= '0;
            idx      <= '0;
            state    <= ST_COMPARE;
          end else if (cnt == CNT_LAST) begin
            auth_fail    <= 1'b1;
            timeout_flag <= 1'b1;
            state        <= ST_FAIL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_COMPARE: begin
          // No early exit: all words are always folded in before the verdict.
          diff     <= diff_next;
          rx_tag   <= rx_tag >> CMP_WIDTH;
          core_tag <= core_tag >> CMP_WIDTH;
          idx      <= idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            if (diff_next == '0) begin
              auth_ok   <= 1'b1;
              pt_valid  <= 1'b1;
              plaintext <= text;
              state     <= ST_RELEASE;
            end else begin
              auth_fail <= 1'b1;
              text      <= '0;
              state     <= ST_FAIL;
            end
          end
        end
        ST_RELEASE: begin
          if (bus.out_ready_in) begin
            pt_valid  <= 1'b0;
            plaintext <= '0;
            text      <= '0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_FAIL: begin
          text  <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.plaintext_out = plaintext;
  assign bus.pt_valid_out  = pt_valid;
  assign bus.auth_ok_out   = auth_ok;
  assign bus.auth_fail_out = auth_fail;
  assign bus.timeout_out   = timeout_flag;
  assign bus.busy_out      = busy;
endmodule
